// File: rtl/countdown_timer_pkg.sv
// Shared types and digit limits for the mm:ss countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SEC_UNITS_MAX = 9;
    localparam int SEC_TENS_MAX  = 5;
    localparam int MIN_UNITS_MAX = 9;
    localparam int MIN_TENS_MAX  = 5;

    // Seconds units sit in the LSBs, so a value of 1 is exactly 00:01.
    typedef struct packed {
        logic [2:0] zm;
        logic [3:0] um;
        logic [2:0] zs;
        logic [3:0] us;
    } time_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control, load-digit and status bundle of the countdown timer.
interface countdown_timer_if;
    logic       fsm_reset;
    logic       valid;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] ld_us;
    logic [2:0] ld_zs;
    logic [3:0] ld_um;
    logic [2:0] ld_zm;
    logic [3:0] out1;
    logic [2:0] out2;
    logic [3:0] out3;
    logic [2:0] out4;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output fsm_reset, valid, load, start, pause, ld_us, ld_zs, ld_um, ld_zm,
        input  out1, out2, out3, out4, running, expired, done
    );

    modport slave (
        input  fsm_reset, valid, load, start, pause, ld_us, ld_zs, ld_um, ld_zm,
        output out1, out2, out3, out4, running, expired, done
    );
endinterface

// File: rtl/countdown_timer_down_counter.sv
// One wrapping decimal digit: counts down to 0, then wraps to MAX and borrows.
module down_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             borrow_out
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = (count_q == '0) ? WIDTH'(MAX) : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out  = count_q;
    assign borrow_out = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer with IDLE/RUN/PAUSE/DONE control.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the loaded value on expiry.
module countdown_timer #(
    parameter bit CLAMP_LOAD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    countdown_timer_if.slave bus
);
    import timer_pkg::*;

    state_e state_q, state_d;
    logic   done_q, done_d;
    time_t  cur, ld_val, cnt_val;
    logic   cnt_load, dec;
    logic   b_us, b_zs, b_um, b_zm;
    logic   is_zero, is_one;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    time_t  shadow_q, shadow_d;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
        return (CLAMP_LOAD && (v > mx)) ? mx : v;
    endfunction

    assign ld_val.us = clamp_digit(bus.ld_us, 4'(SEC_UNITS_MAX));
    assign ld_val.zs = 3'(clamp_digit({1'b0, bus.ld_zs}, 4'(SEC_TENS_MAX)));
    assign ld_val.um = clamp_digit(bus.ld_um, 4'(MIN_UNITS_MAX));
    assign ld_val.zm = 3'(clamp_digit({1'b0, bus.ld_zm}, 4'(MIN_TENS_MAX)));

    // Every digit borrows exactly when it sits at zero, so all four borrows mean 00:00.
    assign is_zero = b_us & b_zs & b_um & b_zm;
    assign is_one  = (cur == 14'd1);

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        dec      = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        shadow_d = shadow_q;
`endif
        if (bus.fsm_reset) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
        end else if (bus.load) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
            cnt_val  = ld_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_d = ld_val;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.pause && bus.start && !is_zero) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (bus.valid) begin
                        if (is_one) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (shadow_q != '0) begin
                                cnt_load = 1'b1;
                                cnt_val  = shadow_q;
                            end else begin
                                dec     = 1'b1;
                                state_d = ST_DONE;
                            end
`else
                            dec     = 1'b1;
                            state_d = ST_DONE;
`endif
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause && bus.start) state_d = ST_RUN;
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    down_counter #(.WIDTH(4), .MAX(SEC_UNITS_MAX)) u_us (
        .clk(clk), .rst(rst), .en(dec), .load(cnt_load), .load_val(cnt_val.us),
        .count_out(cur.us), .borrow_out(b_us)
    );
    down_counter #(.WIDTH(3), .MAX(SEC_TENS_MAX)) u_zs (
        .clk(clk), .rst(rst), .en(dec & b_us), .load(cnt_load), .load_val(cnt_val.zs),
        .count_out(cur.zs), .borrow_out(b_zs)
    );
    down_counter #(.WIDTH(4), .MAX(MIN_UNITS_MAX)) u_um (
        .clk(clk), .rst(rst), .en(dec & b_us & b_zs), .load(cnt_load), .load_val(cnt_val.um),
        .count_out(cur.um), .borrow_out(b_um)
    );
    down_counter #(.WIDTH(3), .MAX(MIN_TENS_MAX)) u_zm (
        .clk(clk), .rst(rst), .en(dec & b_us & b_zs & b_um), .load(cnt_load),
        .load_val(cnt_val.zm), .count_out(cur.zm), .borrow_out(b_zm)
    );

    assign bus.out1    = cur.us;
    assign bus.out2    = cur.zs;
    assign bus.out3    = cur.um;
    assign bus.out4    = cur.zm;
    assign bus.running = (state_q == ST_RUN);
    assign bus.expired = (state_q == ST_DONE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; time values are compared as 16'hMMSS digit nibbles.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    countdown_timer_if bus();

    countdown_timer #(.CLAMP_LOAD(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] tval();
        return {1'b0, bus.out4, bus.out3, 1'b0, bus.out2, bus.out1};
    endfunction

    // {running, expired, done}
    function automatic logic [15:0] flags();
        return {13'd0, bus.running, bus.expired, bus.done};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bcd(input logic [15:0] v);
        bus.ld_us = v[3:0];
        bus.ld_zs = v[6:4];
        bus.ld_um = v[11:8];
        bus.ld_zm = v[14:12];
        bus.load  = 1'b1;
        cyc();
        bus.load  = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic ticks(input int n);
        bus.valid = 1'b1;
        repeat (n) cyc();
        bus.valid = 1'b0;
    endtask

    initial begin
        bus.fsm_reset = 1'b0;
        bus.valid     = 1'b0;
        bus.load      = 1'b0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.ld_us     = '0;
        bus.ld_zs     = '0;
        bus.ld_um     = '0;
        bus.ld_zm     = '0;
        #1;
        chk("reset_value", tval(), 16'h0000);
        chk("reset_flags", flags(), 16'b000);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        load_bcd(16'h0105);
        chk("load_0105", tval(), 16'h0105);
        chk("load_idle", flags(), 16'b000);
        do_start();
        chk("start_run", flags(), 16'b100);
        ticks(5);
        chk("dec_to_0100", tval(), 16'h0100);
        ticks(1);
        chk("wrap_0059", tval(), 16'h0059);
        chk("wrap_flags", flags(), 16'b100);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        load_bcd(16'h0003);
        do_start();
        for (int r = 0; r < 3; r++) begin
            ticks(2);
            chk("reload_0001", tval(), 16'h0001);
            ticks(1);
            chk("reload_value", tval(), 16'h0003);
            chk("reload_flags", flags(), 16'b101);
            cyc();
            chk("reload_pulse_end", flags(), 16'b100);
        end
`else
        load_bcd(16'h0002);
        do_start();
        ticks(1);
        chk("dec_0001", tval(), 16'h0001);
        ticks(1);
        chk("reach_0000", tval(), 16'h0000);
        chk("done_flags", flags(), 16'b011);
        ticks(1);
        chk("done_hold", tval(), 16'h0000);
        chk("done_pulse_end", flags(), 16'b010);
        do_start();
        chk("start_in_done", flags(), 16'b010);
`endif

        load_bcd(16'h1000);
        do_start();
        ticks(1);
        chk("chain_0959", tval(), 16'h0959);
        bus.pause = 1'b1;
        bus.valid = 1'b1;
        cyc();
        bus.pause = 1'b0;
        chk("pause_valid_val", tval(), 16'h0959);
        chk("pause_flags", flags(), 16'b000);
        cyc();
        bus.valid = 1'b0;
        chk("valid_in_pause", tval(), 16'h0959);
        do_start();
        chk("resume_run", flags(), 16'b100);
        ticks(1);
        chk("resume_0958", tval(), 16'h0958);

        bus.valid = 1'b1;
        load_bcd(16'h0007);
        bus.valid = 1'b0;
        chk("load_with_valid", tval(), 16'h0007);
        chk("load_valid_flags", flags(), 16'b000);

        load_bcd(16'h0230);
        do_start();
        ticks(1);
        chk("pre_fsmrst", tval(), 16'h0229);
        bus.fsm_reset = 1'b1;
        cyc();
        bus.fsm_reset = 1'b0;
        chk("fsmrst_value", tval(), 16'h0000);
        chk("fsmrst_flags", flags(), 16'b000);

        bus.ld_us = 4'd12;
        bus.ld_zs = 3'd7;
        bus.ld_um = 4'd0;
        bus.ld_zm = 3'd0;
        bus.load  = 1'b1;
        cyc();
        bus.load  = 1'b0;
        chk("clamp_value", tval(), 16'h0059);
        load_bcd(16'h0000);
        do_start();
        chk("start_zero_flags", flags(), 16'b000);
        cyc();
        chk("start_zero_value", tval(), 16'h0000);

        load_bcd(16'h0318);
        do_start();
        ticks(1);
        chk("pre_rst_0317", tval(), 16'h0317);
        bus.valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_value", tval(), 16'h0000);
        chk("async_rst_flags", flags(), 16'b000);
        bus.valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_flags", flags(), 16'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter CLAMP_LOAD, default 1: 1 clamps out-of-range load digits to their maximum; 0 captures them unmodified.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port fsm_reset, input, 1: synchronous clear to 00:00 and IDLE.
REQ-005 SHALL have port valid, input, 1: one-cycle count tick (1 Hz strobe).
REQ-006 SHALL have port load, input, 1: capture ld_* digits into counter and shadow register.
REQ-007 SHALL have port start, input, 1: begin or resume counting.
REQ-008 SHALL have port pause, input, 1: suspend counting.
REQ-009 SHALL have ports ld_us [3:0], ld_zs [2:0], ld_um [3:0], ld_zm [2:0], inputs: load value for seconds units, seconds tens, minutes units, minutes tens.
REQ-010 SHALL have ports out1 [3:0], out2 [2:0], out3 [3:0], out4 [2:0], outputs: current seconds units, seconds tens, minutes units, minutes tens.
REQ-011 SHALL have port running, output, 1: high in RUN.
REQ-012 SHALL have port expired, output, 1: high in DONE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on reaching 00:00.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-015 SHALL apply input priority rst > fsm_reset > load > pause > start > valid.
REQ-016 load in any state SHALL capture digits next cycle, go to IDLE, and leave done low.
REQ-017 Clamping (CLAMP_LOAD=1) SHALL limit us and um to 9 and zs and zm to 5.
REQ-018 start in IDLE SHALL go to RUN if the value is nonzero; if the value is 00:00, the FSM SHALL stay in IDLE and done SHALL stay low.
REQ-019 pause in RUN SHALL go to PAUSE; start in PAUSE SHALL go to RUN; start and pause SHALL be ignored in DONE.
REQ-020 valid in RUN SHALL decrement by one second in the same edge; valid outside RUN SHALL have no effect.
REQ-021 Digit wrap SHALL be: us 0->9 with borrow; zs 0->5 with borrow only when us borrows; um 0->9 only when both lower digits borrow; zm decrements only on a full borrow chain.
REQ-022 When the decrement result is 00:00, the FSM SHALL go to DONE on the same edge and done SHALL be high for exactly that following cycle.
REQ-023 DONE SHALL hold 00:00 and expired=1 until load, fsm_reset or rst.
REQ-024 Simultaneous pause and valid in RUN SHALL go to PAUSE without decrementing.
REQ-025 Simultaneous load and valid SHALL load; no decrement SHALL occur.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, all out digits 0, shadow register 0, and running, expired and done low.
REQ-027 fsm_reset SHALL produce the same result as rst, synchronously, and the shadow register SHALL be kept.
REQ-028 rst asserted mid-RUN SHALL abort immediately; no done SHALL be emitted.

Configuration
REQ-029 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL control auto-reload.
REQ-030 With COUNTDOWN_AUTO_RELOAD_EN defined, reaching 00:00 SHALL reload the shadow value on the same edge, stay in RUN, and still pulse done; expired SHALL never assert.
REQ-031 Without COUNTDOWN_AUTO_RELOAD_EN, behaviour SHALL be per REQ-022/023 and the shadow register MAY be optimised away.
REQ-032 A zero shadow value with reload enabled SHALL enter DONE as if reload were disabled.

Structure
REQ-033 Package timer_pkg SHALL hold the FSM state enum and the digit maxima (SEC_UNITS_MAX=9, SEC_TENS_MAX=5, MIN_UNITS_MAX=9, MIN_TENS_MAX=5).
REQ-034 A sub-module down_counter (width, MAX; en, load, load_val; count_out, borrow_out) SHALL be instantiated four times and cascaded by borrow AND valid.

Verification
REQ-035 load 01:05, start, 5 valid -> 01:00; 1 more valid -> 00:59.
REQ-036 load 00:02, start, 2 valid -> 00:00, done high 1 cycle, expired=1, further valid ignored.
REQ-037 load 10:00, start, 1 valid -> 09:59; pause with valid same cycle -> stays 09:59, state PAUSE; start, valid -> 09:58.
REQ-038 ld_us=12, ld_zs=7, CLAMP_LOAD=1 -> out1=9, out2=5; start with 00:00 loaded -> stays IDLE, done low.
REQ-039 rst asserted asynchronously mid-RUN at 03:17 -> 00:00, IDLE, all flags low before the next clk edge.
REQ-040 COUNTDOWN_AUTO_RELOAD_EN: load 00:03, run 3 valid -> done pulse, value 00:03, running=1; repeat twice.
